sigma_delta_dac: RTL and testbench
==================================

SIGMA_DELTA_DAC -- requirements
Module: sigma_delta_dac

Interface
REQ-001 SHALL have parameter WIDTH, default 16: PCM sample width, offset-binary.
REQ-002 SHALL have parameter ACC_W, default 20: signed integrator width.
REQ-003 SHALL have parameter OSR, default 64, legal 2..65535: clocks per sample request.
REQ-004 SHALL have port clk  input  1: sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1: advances modulator and counter when high.
REQ-007 SHALL have port pcm_in  input  WIDTH: offset-binary sample from upstream waveform generator.
REQ-008 SHALL have port pcm_valid  input  1: pcm_in valid.
REQ-009 SHALL have port pcm_ready  output  1: registered sample request, one-clock pulse.
REQ-010 SHALL have port clr_flags  input  1: clears sticky flags.
REQ-011 SHALL have port pdm_out  output  1: registered 1-bit density output.
REQ-012 SHALL have port pdm_err  output  WIDTH: first integrator saturated to WIDTH signed bits.
REQ-013 SHALL have port underrun  output  1: sticky, request slot passed with no valid.
REQ-014 SHALL have port overload  output  1: sticky, either integrator clamped.

Function
REQ-015 SHALL hold the accepted sample in register smp; modulator uses smp, never pcm_in directly.
REQ-016 SHALL form signed x = {~smp[WIDTH-1], smp[WIDTH-2:0]}, sign-extended to ACC_W+1 bits.
REQ-017 SHALL form fb = +2^(WIDTH-1) when pdm_out=1, else -2^(WIDTH-1).
REQ-018 SHALL compute s1 = i1 + x - fb at ACC_W+2 bits; i1_next = s1 clamped to [-(2^(ACC_W-1)-1), +(2^(ACC_W-1)-1)].
REQ-019 SHALL compute s2 = i2 + i1_next - fb likewise; i2_next = clamped s2.
REQ-020 SHALL set pdm_out_next = 1 when i2_next >= 0, else 0; pdm_out, i1, i2 update in the same edge (one-clock latency).
REQ-021 SHALL set overload on any edge where either clamp is active.
REQ-022 SHALL keep counter cnt in 0..OSR-1, incrementing per enabled clock and wrapping OSR-1 -> 0.
REQ-023 SHALL drive pcm_ready=1 for exactly the one clock following an enabled edge where cnt wraps to 0; otherwise 0.
REQ-024 SHALL load smp <= pcm_in on an edge where pcm_ready && pcm_valid; the new sample affects the modulator from the next edge.
REQ-025 SHALL, on an edge where pcm_ready && !pcm_valid, hold smp and set underrun.
REQ-026 SHALL ignore pcm_valid when pcm_ready=0.
REQ-027 SHALL clear underrun and overload on clr_flags; a set condition on the same edge wins (flag ends 1).
REQ-028 SHALL, with enable=0, hold i1, i2, pdm_out, cnt, smp; pcm_ready forced 0; an outstanding request is dropped, not counted as underrun.
REQ-029 SHALL drive pdm_err = i1 clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1], registered with i1.

Reset
REQ-030 SHALL on reset set i1=0, i2=0, pdm_out=0, pdm_err=0, cnt=0, pcm_ready=0, underrun=0, overload=0, smp=2^(WIDTH-1) (midscale).
REQ-031 SHALL give reset priority over enable, clr_flags and pcm_valid; reset mid-sample discards smp and restarts cnt at 0.
REQ-032 SHALL issue the first pcm_ready OSR enabled clocks after reset release.

Verification
REQ-033 Reset held 2 clocks, enable=1 -> pdm_out=0, pcm_ready=0, pdm_err=0, flags 0; first pcm_ready 64 clocks after release.
REQ-034 Default params, pcm_valid=1, pcm_in=0x8000 -> after 64 settle clocks, exactly 128 +/-1 ones per 256 clocks; overload stays 0.
REQ-035 pcm_in=0xC000 steady -> 192 +/-2 ones per 256 clocks; pcm_in=0x4000 -> 64 +/-2.
REQ-036 OSR=4, pcm_valid low at the 3rd request -> pcm_ready pulses every 4 clocks; underrun=1 after that slot; smp unchanged; clr_flags pulse on a non-slot clock -> underrun=0.
REQ-037 ACC_W=17, pcm_in=0xFFFF for 2048 clocks -> overload=1, i1/i2 never exceed +/-65535; clr_flags on a clamping clock -> overload remains 1.
REQ-038 Reset asserted for 1 clock mid-stream with pcm_in=0xC000 -> next clock i1=i2=0, pdm_out=0, smp=0x8000, cnt=0.

Source files
------------

// File: rtl/sigma_delta_dac.sv
// sigma_delta_dac
//   Second-order 1-bit sigma-delta modulator for an offset-binary PCM stream.
//   Requests a new sample every OSR enabled clocks and converts it into a
//   pulse-density output. Both integrators saturate, and sticky flags report
//   saturation and missed samples.
//
// Parameters
//   WIDTH  PCM sample width (offset-binary)
//   ACC_W  signed integrator width (must be >= WIDTH)
//   OSR    clocks per sample request, 2..65535
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   enable     advances modulator and sample counter when high
//   pcm_in     offset-binary sample from upstream
//   pcm_valid  pcm_in valid; only looked at while pcm_ready is high
//   pcm_ready  one-clock sample request pulse
//   clr_flags  clears underrun/overload (a same-edge set wins)
//   pdm_out    registered 1-bit density output
//   pdm_err    first integrator saturated to WIDTH signed bits
//   underrun   sticky: a request slot passed without pcm_valid
//   overload   sticky: either integrator clamped
module sigma_delta_dac #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 20,
  parameter int OSR   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] pcm_in,
  input  logic             pcm_valid,
  output logic             pcm_ready,
  input  logic             clr_flags,
  output logic             pdm_out,
  output logic [WIDTH-1:0] pdm_err,
  output logic             underrun,
  output logic             overload
);

  // Two guard bits so i + x - fb can never wrap before the clamp.
  localparam int SW    = ACC_W + 2;
  localparam int CNT_W = $clog2(OSR);

  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(OSR - 1);
  localparam logic [WIDTH-1:0]     MID     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] FB_POS  = SW'(longint'(1) << (WIDTH - 1));
  localparam logic signed [SW-1:0] FB_NEG  = -FB_POS;
  localparam logic signed [SW-1:0] ACC_MAX = SW'((longint'(1) << (ACC_W - 1)) - 1);
  localparam logic signed [SW-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [SW-1:0] ERR_MAX = FB_POS - SW'(1);
  localparam logic signed [SW-1:0] ERR_MIN = FB_NEG;

  logic signed [ACC_W-1:0] i1;
  logic signed [ACC_W-1:0] i2;
  logic        [WIDTH-1:0] smp;
  logic        [CNT_W-1:0] cnt;
  logic                    ready_q;

  logic signed [WIDTH-1:0] x_n;
  logic signed [SW-1:0]    x_w;
  logic signed [SW-1:0]    fb;
  logic signed [SW-1:0]    s1;
  logic signed [SW-1:0]    s2;
  logic signed [SW-1:0]    i1_nx;
  logic signed [SW-1:0]    i2_nx;
  logic signed [SW-1:0]    err_nx;
  logic                    clamp1;
  logic                    clamp2;
  logic                    underrun_set;
  logic                    overload_set;

  // Offset-binary to two's complement: flip the MSB.
  assign x_n = {~smp[WIDTH-1], smp[WIDTH-2:0]};

  always_comb begin
    x_w    = SW'(x_n);
    fb     = pdm_out ? FB_POS : FB_NEG;

    s1     = SW'(i1) + x_w - fb;
    i1_nx  = s1;
    clamp1 = 1'b0;
    if (s1 > ACC_MAX) begin
      i1_nx  = ACC_MAX;
      clamp1 = 1'b1;
    end else if (s1 < ACC_MIN) begin
      i1_nx  = ACC_MIN;
      clamp1 = 1'b1;
    end

    s2     = SW'(i2) + i1_nx - fb;
    i2_nx  = s2;
    clamp2 = 1'b0;
    if (s2 > ACC_MAX) begin
      i2_nx  = ACC_MAX;
      clamp2 = 1'b1;
    end else if (s2 < ACC_MIN) begin
      i2_nx  = ACC_MIN;
      clamp2 = 1'b1;
    end

    err_nx = i1_nx;
    if (i1_nx > ERR_MAX) begin
      err_nx = ERR_MAX;
    end else if (i1_nx < ERR_MIN) begin
      err_nx = ERR_MIN;
    end
  end

  // A request seen while disabled is dropped: no load, no underrun.
  assign underrun_set = enable & ready_q & ~pcm_valid;
  assign overload_set = enable & (clamp1 | clamp2);

  // Gated so upstream never sees a handshake on a clock that ignores it.
  assign pcm_ready = ready_q & enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      i1       <= '0;
      i2       <= '0;
      pdm_out  <= 1'b0;
      pdm_err  <= '0;
      cnt      <= '0;
      ready_q  <= 1'b0;
      smp      <= MID;
      underrun <= 1'b0;
      overload <= 1'b0;
    end else begin
      if (enable) begin
        i1      <= ACC_W'(i1_nx);
        i2      <= ACC_W'(i2_nx);
        pdm_out <= ~i2_nx[SW-1];
        pdm_err <= WIDTH'(err_nx);
        if (cnt == CNT_MAX) begin
          cnt     <= '0;
          ready_q <= 1'b1;
        end else begin
          cnt     <= cnt + CNT_W'(1);
          ready_q <= 1'b0;
        end
        if (ready_q && pcm_valid) begin
          smp <= pcm_in;
        end
      end else begin
        ready_q <= 1'b0;
      end
      underrun <= underrun_set | (underrun & ~clr_flags);
      overload <= overload_set | (overload & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_sigma_delta_dac.sv
module tb_sigma_delta_dac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Default-parameter instance
  logic        d_rst = 1'b1, d_en = 1'b1, d_valid = 1'b1, d_clr = 1'b0;
  logic [15:0] d_pcm = 16'h8000;
  logic        d_ready, d_pdm, d_unr, d_ovl;
  logic [15:0] d_err;

  // OSR=4 instance
  logic        o_rst = 1'b1, o_en = 1'b1, o_valid = 1'b1, o_clr = 1'b0;
  logic [15:0] o_pcm = 16'h1234;
  logic        o_ready, o_pdm, o_unr, o_ovl;
  logic [15:0] o_err;

  // ACC_W=17 instance
  logic        a_rst = 1'b1, a_en = 1'b1, a_valid = 1'b1, a_clr = 1'b0;
  logic [15:0] a_pcm = 16'hFFFF;
  logic        a_ready, a_pdm, a_unr, a_ovl;
  logic [15:0] a_err;

  sigma_delta_dac u_d (
    .clk(clk), .reset(d_rst), .enable(d_en), .pcm_in(d_pcm), .pcm_valid(d_valid),
    .pcm_ready(d_ready), .clr_flags(d_clr), .pdm_out(d_pdm), .pdm_err(d_err),
    .underrun(d_unr), .overload(d_ovl)
  );

  sigma_delta_dac #(.OSR(4)) u_o4 (
    .clk(clk), .reset(o_rst), .enable(o_en), .pcm_in(o_pcm), .pcm_valid(o_valid),
    .pcm_ready(o_ready), .clr_flags(o_clr), .pdm_out(o_pdm), .pdm_err(o_err),
    .underrun(o_unr), .overload(o_ovl)
  );

  sigma_delta_dac #(.ACC_W(17)) u_a17 (
    .clk(clk), .reset(a_rst), .enable(a_en), .pcm_in(a_pcm), .pcm_valid(a_valid),
    .pcm_ready(a_ready), .clr_flags(a_clr), .pdm_out(a_pdm), .pdm_err(a_err),
    .underrun(a_unr), .overload(a_ovl)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hand-traced first six outputs from reset with midscale input.
  logic        exp_pdm [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [15:0] exp_err [6] = '{16'h7FFF, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000};

  int ones;
  int over_rng;

  initial begin
    // ---------------- default instance: reset + first request ----------------
    step();
    step();
    chk("rst_pdm", 32'(d_pdm), 32'(0));
    chk("rst_ready", 32'(d_ready), 32'(0));
    chk("rst_err", 32'(d_err), 32'(0));
    chk("rst_unr", 32'(d_unr), 32'(0));
    chk("rst_ovl", 32'(d_ovl), 32'(0));
    d_rst = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      step();
      chk($sformatf("first_ready_k%0d", k), 32'(d_ready), 32'(k == 64));
      if (k <= 6) begin
        chk($sformatf("trace_pdm_k%0d", k), 32'(d_pdm), 32'(exp_pdm[k-1]));
        chk($sformatf("trace_err_k%0d", k), 32'(d_err), 32'(exp_err[k-1]));
      end
    end

    // ---------------- densities ----------------
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      ones += int'(d_pdm);
    end
    chk("dens_8000", 32'(ones >= 127 && ones <= 129), 32'(1));
    chk("ovl_8000", 32'(d_ovl), 32'(0));
    chk("unr_8000", 32'(d_unr), 32'(0));

    d_pcm = 16'hC000;
    for (int i = 0; i < 128; i++) step();
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      ones += int'(d_pdm);
    end
    chk("dens_C000", 32'(ones >= 190 && ones <= 194), 32'(1));

    d_pcm = 16'h4000;
    for (int i = 0; i < 128; i++) step();
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      ones += int'(d_pdm);
    end
    chk("dens_4000", 32'(ones >= 62 && ones <= 66), 32'(1));
    chk("ovl_4000", 32'(d_ovl), 32'(0));

    // ---------------- mid-stream reset ----------------
    d_pcm = 16'hC000;
    for (int i = 0; i < 100; i++) step();
    chk("pre_rst_smp", 32'(u_d.smp), 32'h0000C000);
    d_rst = 1'b1;
    step();
    d_rst = 1'b0;
    chk("mrst_i1", 32'(u_d.i1), 32'(0));
    chk("mrst_i2", 32'(u_d.i2), 32'(0));
    chk("mrst_pdm", 32'(d_pdm), 32'(0));
    chk("mrst_smp", 32'(u_d.smp), 32'h00008000);
    chk("mrst_cnt", 32'(u_d.cnt), 32'(0));
    chk("mrst_ready", 32'(d_ready), 32'(0));
    chk("mrst_err", 32'(d_err), 32'(0));
    for (int i = 0; i < 63; i++) step();
    chk("mrst_ready_63", 32'(d_ready), 32'(0));
    step();
    chk("mrst_ready_64", 32'(d_ready), 32'(1));

    // ---------------- OSR=4 handshake / underrun / enable ----------------
    o_rst = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      step();
      chk($sformatf("o4_ready_k%0d", k), 32'(o_ready),
          32'(((k % 4) == 0 && k <= 20) || k == 25));
      case (k)
        5:  begin chk("o4_smp_k5", 32'(u_o4.smp), 32'h1234); o_pcm = 16'h5678; end
        8:  chk("o4_smp_k8", 32'(u_o4.smp), 32'h1234);
        9:  chk("o4_smp_k9", 32'(u_o4.smp), 32'h5678);
        12: begin chk("o4_unr_k12", 32'(o_unr), 32'(0)); o_valid = 1'b0; o_pcm = 16'h9ABC; end
        13: begin
              chk("o4_unr_k13", 32'(o_unr), 32'(1));
              chk("o4_smp_k13", 32'(u_o4.smp), 32'h5678);
              o_valid = 1'b1; o_clr = 1'b1;
            end
        14: begin chk("o4_clr_k14", 32'(o_unr), 32'(0)); o_clr = 1'b0; end
        16: begin o_valid = 1'b0; o_clr = 1'b1; end
        17: begin
              chk("o4_setwins_k17", 32'(o_unr), 32'(1));
              chk("o4_smp_k17", 32'(u_o4.smp), 32'h5678);
              o_valid = 1'b1;
            end
        18: begin chk("o4_clr_k18", 32'(o_unr), 32'(0)); o_clr = 1'b0; end
        20: begin
              o_en = 1'b0; o_valid = 1'b0;
              #1;
              chk("o4_gated_k20", 32'(o_ready), 32'(0));
            end
        21: begin
              chk("o4_drop_unr_k21", 32'(o_unr), 32'(0));
              chk("o4_hold_cnt_k21", 32'(u_o4.cnt), 32'(0));
              chk("o4_hold_smp_k21", 32'(u_o4.smp), 32'h5678);
              o_en = 1'b1; o_valid = 1'b1;
            end
        26: chk("o4_smp_k26", 32'(u_o4.smp), 32'h9ABC);
        default: ;
      endcase
    end

    // ---------------- ACC_W=17 full-scale overload ----------------
    a_rst = 1'b0;
    over_rng = 0;
    for (int k = 1; k <= 2048; k++) begin
      step();
      if (u_a17.i1 == -17'sd65536 || u_a17.i2 == -17'sd65536) over_rng++;
      if (k == 1500) begin
        chk("a17_i2_rail", 32'(u_a17.i2), 32'(65535));
        chk("a17_pdm", 32'(a_pdm), 32'(1));
        chk("a17_err_sat", 32'(a_err), 32'h7FFF);
        chk("a17_ovl_k1500", 32'(a_ovl), 32'(1));
        a_clr = 1'b1;
      end
      if (k == 1501) begin
        chk("a17_clr_on_clamp", 32'(a_ovl), 32'(1));
        a_clr = 1'b0;
      end
    end
    chk("a17_ovl_end", 32'(a_ovl), 32'(1));
    chk("a17_range", 32'(over_rng), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
